lfsr_pingpong_cnt: RTL

- Parametrised photon-counting pixel counter with two LFSR banks for continuous (dead-time-free) readout.
- One bank counts synchronous hit strobes while the other is serially shifted out through the pixel column chain. A frame-swap strobe exchanges the roles of the two banks.
- Counting is single-clock synchronous. The pulse front-end delivers pre-synchronised one-cycle strobes, so there is no clock muxing.

---
 rtl/lfsr_pkg.sv | 74 +++++++
 rtl/lfsr_pingpong_cnt_if.sv | 28 ++
 rtl/lfsr_bank.sv | 84 ++++++++
 rtl/lfsr_pingpong_cnt.sv | 95 +++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and elaboration-time helpers for the LFSR
// ping-pong pixel counter.
//   taps(width)      Fibonacci feedback mask, bit k-1 set for tap k (4..24)
//   all_ones(width)  width low bits set (bank reset / frame-start value)
//   sat_state(width) LFSR predecessor of all-ones (saturation state)
//   width_ok(width)  legal-range predicate for the WIDTH parameter
// Optional feature macro used by the importers: LFSR_SAT_EN.
package lfsr_pkg;

  localparam int unsigned MinWidth = 4;
  localparam int unsigned MaxWidth = 24;

  function automatic logic [MaxWidth-1:0] tap_bit(int unsigned k);
    return {{(MaxWidth-1){1'b0}}, 1'b1} << (k - 1);
  endfunction

  // Maximal-length tap sets, one primitive polynomial per width.
  function automatic logic [MaxWidth-1:0] taps(int unsigned width);
    logic [MaxWidth-1:0] m;
    m = '0;
    case (width)
      4:  m = tap_bit(4)  | tap_bit(3);
      5:  m = tap_bit(5)  | tap_bit(3);
      6:  m = tap_bit(6)  | tap_bit(5);
      7:  m = tap_bit(7)  | tap_bit(6);
      8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
      9:  m = tap_bit(9)  | tap_bit(5);
      10: m = tap_bit(10) | tap_bit(7);
      11: m = tap_bit(11) | tap_bit(9);
      12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
      14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
      15: m = tap_bit(15) | tap_bit(14);
      16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17: m = tap_bit(17) | tap_bit(14);
      18: m = tap_bit(18) | tap_bit(11);
      19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      20: m = tap_bit(20) | tap_bit(17);
      21: m = tap_bit(21) | tap_bit(19);
      22: m = tap_bit(22) | tap_bit(21);
      23: m = tap_bit(23) | tap_bit(18);
      24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [MaxWidth-1:0] all_ones(int unsigned width);
    logic [MaxWidth-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < width; i++) m[i] = 1'b1;
    return m;
  endfunction

  // The predecessor p of all-ones has p[W-1:1] all ones (they shift up into
  // bits W..2), and its top bit must make the feedback come out as 1. The top
  // tap is always present, so p[W] = 1 ^ parity of the remaining taps.
  function automatic logic [MaxWidth-1:0] sat_state(int unsigned width);
    logic [MaxWidth-1:0] t;
    logic [MaxWidth-1:0] p;
    logic                low_par;
    t       = taps(width);
    p       = all_ones(width);
    low_par = 1'b0;
    for (int unsigned i = 0; i + 1 < width; i++) low_par = low_par ^ t[i];
    p[width-1] = ~low_par;
    return p;
  endfunction

  function automatic bit width_ok(int unsigned width);
    return (width >= MinWidth) && (width <= MaxWidth);
  endfunction

endpackage

// File: rtl/lfsr_pingpong_cnt_if.sv
// lfsr_pingpong_cnt_if: pixel-side signal bundle of the ping-pong counter.
//   pulse_in     one-cycle hit strobe
//   frame_swap   one-cycle frame close / bank swap strobe
//   shift_en     shift the read bank one position
//   ser_in       serial column chain input (enters read bank bit 1)
//   ser_out      read bank MSB
//   active_bank  index of the counting bank
//   frame_ovf    overflow flag of the frame held in the read bank
// master = pixel controller / column logic, slave = the counter.
interface lfsr_pingpong_cnt_if;
  logic pulse_in;
  logic frame_swap;
  logic shift_en;
  logic ser_in;
  logic ser_out;
  logic active_bank;
  logic frame_ovf;

  modport master (
    output pulse_in, frame_swap, shift_en, ser_in,
    input  ser_out, active_bank, frame_ovf
  );

  modport slave (
    input  pulse_in, frame_swap, shift_en, ser_in,
    output ser_out, active_bank, frame_ovf
  );
endinterface

// File: rtl/lfsr_bank.sv
// lfsr_bank: one WIDTH-bit Fibonacci LFSR counter / shift register bank.
//   clock, reset  rising-edge clock, asynchronous active-high reset (to all-ones)
//   count         advance one LFSR step
//   shift         shift left one position, ser_in into bit 1
//   load_ones     restart the frame (all-ones, overflow cleared); wins over all
//   ser_in        serial input
//   msb           state bit WIDTH
//   ovf, at_sat   sticky overflow / state is saturated (only with LFSR_SAT_EN)
// With LFSR_SAT_EN defined a count in the saturation state holds and sets ovf.
module lfsr_bank
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic count,
  input  logic shift,
  input  logic load_ones,
  input  logic ser_in,
  output logic msb
`ifdef LFSR_SAT_EN
  ,
  output logic ovf,
  output logic at_sat
`endif
);

  localparam logic [MaxWidth-1:0] TapsFull = taps(WIDTH);
  localparam logic [MaxWidth-1:0] OnesFull = all_ones(WIDTH);
  localparam logic [WIDTH-1:0]    Taps     = TapsFull[WIDTH-1:0];
  localparam logic [WIDTH-1:0]    AllOnes  = OnesFull[WIDTH-1:0];

  logic [WIDTH-1:0] state_q, state_d;
  logic             feedback;
  logic             hold;

  assign feedback = ^(state_q & Taps);

`ifdef LFSR_SAT_EN
  localparam logic [MaxWidth-1:0] SatFull  = sat_state(WIDTH);
  localparam logic [WIDTH-1:0]    SatState = SatFull[WIDTH-1:0];

  logic ovf_q;

  assign hold   = (state_q == SatState);
  assign at_sat = hold;
  assign ovf    = ovf_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (load_ones) begin
      ovf_q <= 1'b0;
    end else if (count && hold) begin
      ovf_q <= 1'b1;
    end
  end
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (load_ones) begin
      state_d = AllOnes;
    end else if (count) begin
      if (!hold) state_d = {state_q[WIDTH-2:0], feedback};
    end else if (shift) begin
      state_d = {state_q[WIDTH-2:0], ser_in};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= AllOnes;
    end else begin
      state_q <= state_d;
    end
  end

  assign msb = state_q[WIDTH-1];

endmodule

// File: rtl/lfsr_pingpong_cnt.sv
// lfsr_pingpong_cnt: photon-counting pixel counter with two LFSR banks.
// One bank counts pulse_in while the other is shifted out MSB-first on the
// column chain; frame_swap exchanges the roles and restarts the new counting
// bank at all-ones.
//   WIDTH        LFSR bits, 4..24
//   clock        rising-edge clock
//   reset        asynchronous active-high: banks all-ones, active_bank=0,
//                frame_ovf=0
//   bus (slave)  pulse_in, frame_swap, shift_en, ser_in -> ser_out,
//                active_bank, frame_ovf
// Macro LFSR_SAT_EN: saturate at the predecessor of all-ones and report
// overflow; undefined, the counter wraps and frame_ovf is tied low.
module lfsr_pingpong_cnt
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 15
) (
  input logic                 clock,
  input logic                 reset,
  lfsr_pingpong_cnt_if.slave  bus
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("lfsr_pingpong_cnt: WIDTH %0d outside 4..24", WIDTH);
  end

  logic       active_bank_q;
  logic [1:0] is_active;
  logic [1:0] bank_count, bank_shift, bank_load;
  logic [1:0] bank_msb;

  assign is_active = {active_bank_q, ~active_bank_q};

  // The closing bank still takes a same-cycle pulse; shifting is suppressed
  // on the swap cycle because the read bank is being reloaded.
  assign bank_count = is_active & {2{bus.pulse_in}};
  assign bank_shift = ~is_active & {2{bus.shift_en & ~bus.frame_swap}};
  assign bank_load  = ~is_active & {2{bus.frame_swap}};

`ifdef LFSR_SAT_EN
  logic [1:0] bank_ovf, bank_sat;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    lfsr_bank #(
      .WIDTH(WIDTH)
    ) u_bank (
      .clock     (clock),
      .reset     (reset),
      .count     (bank_count[b]),
      .shift     (bank_shift[b]),
      .load_ones (bank_load[b]),
      .ser_in    (bus.ser_in),
      .msb       (bank_msb[b])
`ifdef LFSR_SAT_EN
      ,
      .ovf       (bank_ovf[b]),
      .at_sat    (bank_sat[b])
`endif
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_bank_q <= 1'b0;
    end else if (bus.frame_swap) begin
      active_bank_q <= ~active_bank_q;
    end
  end

`ifdef LFSR_SAT_EN
  logic frame_ovf_q;
  logic closing_ovf;

  // Include an overflow caused by a pulse landing on the swap edge itself.
  assign closing_ovf = active_bank_q ? (bank_ovf[1] | (bus.pulse_in & bank_sat[1]))
                                     : (bank_ovf[0] | (bus.pulse_in & bank_sat[0]));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_ovf_q <= 1'b0;
    end else if (bus.frame_swap) begin
      frame_ovf_q <= closing_ovf;
    end
  end

  assign bus.frame_ovf = frame_ovf_q;
`else
  assign bus.frame_ovf = 1'b0;
`endif

  assign bus.active_bank = active_bank_q;
  assign bus.ser_out     = active_bank_q ? bank_msb[0] : bank_msb[1];

endmodule
